// File: rtl/conf_loader_if.sv
// Signal bundle connecting conf_loader to its requester, the configuration memory and the register file.
// Handshake: start is a single-cycle request, accepted only while the loader is idle
// (busy=0 and done=0). There is no ready/backpressure; a requester waits for done and
// may issue the next start in the cycle after done.
interface conf_loader_if #(
    parameter int MEM_ADDR_W = 16
);
    logic                  start;
    logic [MEM_ADDR_W-1:0] base_addr;
    logic [5:0]            first_index;
    logic [5:0]            num_words;
    logic                  mem_rd_en;
    logic [MEM_ADDR_W-1:0] mem_rd_addr;
    logic [31:0]           mem_rd_data;
    logic                  wr_en_ext;
    logic [31:0]           wr_addr_ext;
    logic [31:0]           wr_data_ext;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [1:0]            state_dbg;

    modport master (
        input  start, base_addr, first_index, num_words, mem_rd_data,
        output mem_rd_en, mem_rd_addr, wr_en_ext, wr_addr_ext, wr_data_ext,
               busy, done, err, state_dbg
    );

    modport slave (
        output start, base_addr, first_index, num_words, mem_rd_data,
        input  mem_rd_en, mem_rd_addr, wr_en_ext, wr_addr_ext, wr_data_ext,
               busy, done, err, state_dbg
    );
endinterface

// File: rtl/conf_loader.sv
// Configuration loader: streams a block of words from configuration memory into the
// register file, one pipelined read per cycle and one in-order write per returned word.
module conf_loader #(
    parameter int CONF_REGISTERS_SIZE = 32,
    parameter int MEM_ADDR_W          = 16,
    parameter int MEM_RD_LATENCY      = 1
) (
    input  logic          clk,
    input  logic          reset,
    conf_loader_if.master bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FETCH  = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;
    localparam logic [6:0] REG_LIMIT = 7'(CONF_REGISTERS_SIZE);

    logic [1:0]                state_q, state_d;
    logic                      rd_en_q, rd_en_d;
    logic [MEM_ADDR_W-1:0]     rd_addr_q, rd_addr_d;
    logic [5:0]                first_q, first_d;
    logic [5:0]                num_q, num_d;
    logic [5:0]                rd_cnt_q, rd_cnt_d;
    logic [5:0]                wr_cnt_q, wr_cnt_d;
    logic [MEM_RD_LATENCY-1:0] vld_q, vld_d;
    logic                      wr_en_q, wr_en_d;
    logic [31:0]               wr_addr_q, wr_addr_d;
    logic [31:0]               wr_data_q, wr_data_d;
    logic                      err_q, err_d;

    logic [6:0] end_index;
    logic       ret_valid;
    logic       accept;

    // Range check on a 7-bit sum so first_index up to 63 plus 32 words cannot wrap.
    assign end_index = {1'b0, bus.first_index} + {1'b0, bus.num_words};
    assign ret_valid = vld_q[MEM_RD_LATENCY-1];
    assign accept    = (state_q == S_IDLE) && bus.start;

    always_comb begin
        state_d   = state_q;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        first_d   = first_q;
        num_d     = num_q;
        rd_cnt_d  = rd_cnt_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    first_d  = bus.first_index;
                    num_d    = bus.num_words;
                    err_d    = 1'b0;
                    rd_cnt_d = '0;
                    if (end_index > REG_LIMIT) begin
                        err_d   = 1'b1;
                        state_d = S_FINISH;
                    end else if (bus.num_words == '0) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d   = S_FETCH;
                        rd_en_d   = 1'b1;
                        rd_addr_d = bus.base_addr;
                        rd_cnt_d  = 6'd1;
                    end
                end
            end
            S_FETCH: begin
                // rd_cnt_q counts reads issued including the one on the bus this cycle.
                if (rd_cnt_q == num_q) begin
                    state_d = S_DRAIN;
                end else begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = rd_addr_q + MEM_ADDR_W'(1);
                    rd_cnt_d  = rd_cnt_q + 6'd1;
                end
            end
            S_DRAIN: begin
                if (wr_en_q && (wr_cnt_q == num_q)) begin
                    state_d = S_FINISH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        vld_d    = '0;
        vld_d[0] = rd_en_q;
        for (int i = 1; i < MEM_RD_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
        end
        wr_en_d   = ret_valid;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_cnt_d  = wr_cnt_q;
        if (accept) begin
            wr_cnt_d = '0;
        end
        if (ret_valid) begin
            wr_addr_d = {26'd0, first_q + wr_cnt_q};
            wr_data_d = bus.mem_rd_data;
            wr_cnt_d  = wr_cnt_q + 6'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            first_q   <= '0;
            num_q     <= '0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            vld_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            first_q   <= first_d;
            num_q     <= num_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            vld_q     <= vld_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            err_q     <= err_d;
        end
    end

    assign bus.mem_rd_en   = rd_en_q;
    assign bus.mem_rd_addr = rd_addr_q;
    assign bus.wr_en_ext   = wr_en_q;
    assign bus.wr_addr_ext = wr_addr_q;
    assign bus.wr_data_ext = wr_data_q;
    assign bus.err         = err_q;
    assign bus.done        = (state_q == S_FINISH);
    // A real load drops busy after its last write; empty/errored requests are busy only in their done cycle.
    assign bus.busy        = (state_q == S_FETCH) || (state_q == S_DRAIN) ||
                             ((state_q == S_FINISH) && (err_q || (num_q == '0)));
    assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_conf_loader.sv
// Bench for conf_loader: four instances with read latency 1..4 share one stimulus stream,
// each checked against a cycle-level model of reads, writes, done, busy and err.
`timescale 1ns/1ps
module tb_conf_loader;
    localparam int NI = 4;
    localparam int AW = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          start_r = 1'b0;
    logic [AW-1:0] base_r  = '0;
    logic [5:0]    first_r = '0;
    logic [5:0]    num_r   = '0;

    logic [31:0] mem [0:65535];

    logic [NI-1:0]    rd_en_w, wr_en_w, busy_w, done_w, err_w;
    logic [NI*16-1:0] rd_addr_w;
    logic [NI*32-1:0] wr_addr_w, wr_data_w;

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int LAT = g + 1;
        conf_loader_if #(.MEM_ADDR_W(AW)) bus ();
        logic [31:0] pipe [LAT];

        assign bus.start       = start_r;
        assign bus.base_addr   = base_r;
        assign bus.first_index = first_r;
        assign bus.num_words   = num_r;
        assign bus.mem_rd_data = pipe[LAT-1];

        assign rd_en_w[g]             = bus.mem_rd_en;
        assign rd_addr_w[g*16 +: 16]  = bus.mem_rd_addr;
        assign wr_en_w[g]             = bus.wr_en_ext;
        assign wr_addr_w[g*32 +: 32]  = bus.wr_addr_ext;
        assign wr_data_w[g*32 +: 32]  = bus.wr_data_ext;
        assign busy_w[g]              = bus.busy;
        assign done_w[g]              = bus.done;
        assign err_w[g]               = bus.err;

        // Memory model: data for a strobe sampled at edge e is presented after edge e+LAT-1.
        always @(posedge clk) begin
            pipe[0] <= bus.mem_rd_en ? mem[bus.mem_rd_addr] : 32'hDEAD_BEEF;
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        end

        conf_loader #(
            .CONF_REGISTERS_SIZE(32),
            .MEM_ADDR_W(AW),
            .MEM_RD_LATENCY(LAT)
        ) dut (
            .clk(clk),
            .reset(reset),
            .bus(bus)
        );
    end

    logic [95:0] rd_exp [NI][$];
    logic [95:0] wr_exp [NI][$];
    int exp_done  [NI];
    int exp_busy  [NI];
    int done_seen [NI];
    int busy_cnt  [NI];
    int t0    = 0;
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every observed event is matched in order against the expected queues.
    always @(negedge clk) begin
        logic [15:0] rel;
        rel = 16'(cyc - t0);
        for (int i = 0; i < NI; i++) begin
            if (rd_en_w[i]) begin
                if (rd_exp[i].size() == 0)
                    check("rd_extra", {63'd0, 1'b1, rel, rd_addr_w[i*16 +: 16]}, 96'd0);
                else
                    check("rd", {64'd0, rel, rd_addr_w[i*16 +: 16]}, rd_exp[i].pop_front());
            end
            if (wr_en_w[i]) begin
                if (wr_exp[i].size() == 0)
                    check("wr_extra", {15'd0, 1'b1, rel, wr_addr_w[i*32 +: 32], wr_data_w[i*32 +: 32]}, 96'd0);
                else
                    check("wr", {16'd0, rel, wr_addr_w[i*32 +: 32], wr_data_w[i*32 +: 32]}, wr_exp[i].pop_front());
            end
            if (done_w[i]) begin
                check("done_cyc", {80'd0, rel}, 96'(exp_done[i]));
                done_seen[i]++;
            end
            if (busy_w[i]) busy_cnt[i]++;
        end
    end

    // Reference model: timing derived from cycle 0 = start sampled, L = instance latency.
    task automatic build_model(input logic [15:0] base, input int first, input int num);
        for (int i = 0; i < NI; i++) begin
            int lat;
            bit short_req;
            lat = i + 1;
            short_req = ((first + num) > 32) || (num == 0);
            rd_exp[i].delete();
            wr_exp[i].delete();
            done_seen[i] = 0;
            busy_cnt[i]  = 0;
            exp_done[i]  = short_req ? 1 : num + lat + 2;
            exp_busy[i]  = short_req ? 1 : num + lat + 1;
            if (!short_req) begin
                for (int j = 0; j < num; j++) begin
                    logic [15:0] a;
                    a = base + 16'(j);
                    rd_exp[i].push_back({64'd0, 16'(1 + j), a});
                    wr_exp[i].push_back({16'd0, 16'(2 + lat + j), 32'(first + j), mem[a]});
                end
            end
        end
    endtask

    task automatic run_req(input logic [15:0] base, input int first, input int num, input bit poke_busy);
        bit exp_err;
        bit all_done;
        exp_err = (first + num) > 32;
        for (int j = 0; j < num; j++) mem[base + 16'(j)] = $urandom;
        @(posedge clk); #1;
        build_model(base, first, num);
        t0      = cyc;
        start_r = 1'b1;
        base_r  = base;
        first_r = 6'(first);
        num_r   = 6'(num);
        @(posedge clk); #1;
        start_r = 1'b0;
        base_r  = 16'($urandom);
        first_r = 6'($urandom);
        num_r   = 6'($urandom);
        @(negedge clk);
        for (int i = 0; i < NI; i++) check("err_cycle1", 96'(err_w[i]), 96'(exp_err));
        if (poke_busy) begin
            @(posedge clk); #1;
            @(posedge clk); #1;
            start_r = 1'b1;
            base_r  = base + 16'h0100;
            first_r = 6'd0;
            num_r   = 6'd5;
            @(posedge clk); #1;
            start_r = 1'b0;
        end
        all_done = 1'b0;
        for (int k = 0; k < 400 && !all_done; k++) begin
            @(negedge clk);
            all_done = 1'b1;
            for (int i = 0; i < NI; i++) if (done_seen[i] == 0) all_done = 1'b0;
        end
        check("done_timeout", {95'd0, all_done}, 96'd1);
        if (poke_busy) repeat (10) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check("rd_missing", 96'(rd_exp[i].size()), 96'd0);
            check("wr_missing", 96'(wr_exp[i].size()), 96'd0);
            check("done_count", 96'(done_seen[i]), 96'd1);
            check("busy_cycles", 96'(busy_cnt[i]), 96'(exp_busy[i]));
            check("err_hold", 96'(err_w[i]), 96'(exp_err));
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        for (int i = 0; i < NI; i++) begin
            check(tag, 96'({rd_en_w[i], wr_en_w[i], busy_w[i], done_w[i], err_w[i],
                            rd_addr_w[i*16 +: 16], wr_addr_w[i*32 +: 32], wr_data_w[i*32 +: 32]}), 96'd0);
        end
    endtask

    task automatic reset_mid_load();
        logic [15:0] base;
        base = 16'($urandom);
        for (int j = 0; j < 10; j++) mem[base + 16'(j)] = $urandom;
        @(posedge clk); #1;
        build_model(base, 0, 10);
        t0      = cyc;
        start_r = 1'b1;
        base_r  = base;
        first_r = 6'd0;
        num_r   = 6'd10;
        @(posedge clk); #1;
        start_r = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        check_outputs_zero("reset_midload_outs");
        for (int i = 0; i < NI; i++) begin
            rd_exp[i].delete();
            wr_exp[i].delete();
            exp_done[i] = -1;
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            exp_done[i]  = -1;
            exp_busy[i]  = 0;
            done_seen[i] = 0;
            busy_cnt[i]  = 0;
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset_outs");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        run_req(16'h0100, 0, 3, 1'b0);
        run_req(16'h2000, 0, 32, 1'b0);
        run_req(16'h0300, 30, 3, 1'b0);
        run_req(16'h0400, 5, 7, 1'b0);
        run_req(16'h0500, 4, 0, 1'b0);
        run_req(16'h0600, 31, 1, 1'b0);
        run_req(16'hFFFF, 9, 2, 1'b0);
        run_req(16'h0700, 33, 0, 1'b0);
        reset_mid_load();
        run_req(16'h0800, 2, 10, 1'b0);
        run_req(16'h0900, 1, 10, 1'b1);
        for (int r = 0; r < 25; r++) begin
            run_req(16'($urandom), int'($urandom_range(0, 40)), int'($urandom_range(0, 32)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
